tcu_tile_sequencer: RTL and testbench

Tensor-core execution shell that computes a full D = A×B + C tile (TILE_M×TILE_N outputs, depth K) using a smaller, parametrised number of dot-product lanes. The tile is time-multiplexed over several passes, and the block supports two operand formats (int32, packed int8x4). It sits between the TCU dispatch stage and writeback. Upstream and downstream use valid/ready handshakes, and one global stall freezes the datapath whenever the result register is held.

---
 rtl/tcu_tile_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_tcu_tile_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tcu_tile_sequencer.sv
// Tensor-core tile shell: D = A*B + C over a TILE_M x TILE_N tile, computed in
// P = TILE_M*TILE_N/NUM_LANES passes through NUM_LANES dot-product lanes.

module tcu_dot_lane #(
  parameter int TILE_K = 4
) (
  input  logic                   fmt,
  input  logic [TILE_K-1:0][31:0] a,
  input  logic [TILE_K-1:0][31:0] b,
  input  logic [31:0]            c,
  output logic [31:0]            d
);
  logic [31:0]        acc;
  logic signed [15:0] sa, sb, prod;

  always_comb begin
    acc  = c;
    sa   = '0;
    sb   = '0;
    prod = '0;
    for (int k = 0; k < TILE_K; k++) begin
      if (fmt) begin
        // int8x4: four signed byte products per word, each fits in 16 bits
        for (int y = 0; y < 4; y++) begin
          sa   = 16'($signed(a[k][8*y +: 8]));
          sb   = 16'($signed(b[k][8*y +: 8]));
          prod = sa * sb;
          acc  = acc + {{16{prod[15]}}, prod};
        end
      end else begin
        acc = acc + a[k] * b[k];
      end
    end
    d = acc;
  end
endmodule

module tcu_tile_sequencer #(
  parameter int TILE_M    = 2,
  parameter int TILE_N    = 2,
  parameter int TILE_K    = 4,
  parameter int NUM_LANES = 2,
  parameter int LATENCY   = 3,
  parameter int TAGW      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [TAGW-1:0]               in_tag,
  input  logic                          in_fmt,
  input  logic [TILE_M*TILE_K*32-1:0]   in_a,
  input  logic [TILE_N*TILE_K*32-1:0]   in_b,
  input  logic [TILE_M*TILE_N*32-1:0]   in_c,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [TAGW-1:0]               out_tag,
  output logic [TILE_M*TILE_N*32-1:0]   out_d
);
  localparam int NE = TILE_M * TILE_N;
  localparam int P  = NE / NUM_LANES;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int EW = (NE > 1) ? $clog2(NE) : 1;
  localparam int IW = (TILE_M > 1) ? $clog2(TILE_M) : 1;
  localparam int JW = (TILE_N > 1) ? $clog2(TILE_N) : 1;

  typedef logic [NUM_LANES-1:0][31:0] lanes_t;
  typedef struct packed {
    logic                           fmt;
    logic [TAGW-1:0]                tag;
    logic [TILE_M-1:0][TILE_K-1:0][31:0] a;
    logic [TILE_N-1:0][TILE_K-1:0][31:0] b;
    logic [NE-1:0][31:0]            c;
  } op_t;
  typedef struct packed {
    logic [PW-1:0]   pass;
    logic            last;
    logic [TAGW-1:0] tag;
    lanes_t          res;
  } meta_t;
  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       pass_q, pass_d;
  op_t                 op_q, op_d;
  logic [NE-1:0][31:0] asm_q, asm_d, out_d_q, out_d_d;
  logic [TAGW-1:0]     out_tag_q, out_tag_d;
  logic                out_valid_q, out_valid_d;
  logic                en, last_pass, s0_vld, wb_vld;
  meta_t               s0_meta, wb_meta;
  lanes_t              lane_d;

  assign en        = !(out_valid_q && !out_ready);
  assign last_pass = (pass_q == PW'(P - 1));

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    op_d     = op_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = en;
      S_ISSUE: begin
        in_ready = en && last_pass;
        if (en) begin
          if (last_pass) state_d = S_IDLE;
          else           pass_d  = pass_q + PW'(1);
        end
      end
    endcase
    // A request taken on the last pass restarts at pass 0: no bubble.
    if (in_valid && in_ready) begin
      op_d.fmt = in_fmt;
      op_d.tag = in_tag;
      op_d.a   = in_a;
      op_d.b   = in_b;
      op_d.c   = in_c;
      pass_d   = '0;
      state_d  = S_ISSUE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
    end
  end

  always_ff @(posedge clk) op_q <= op_d;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [EW-1:0] ei;
    logic [IW-1:0] ri;
    logic [JW-1:0] cj;
    always_comb begin
      ei = EW'(int'(pass_q) * NUM_LANES + l);
      ri = IW'(ei / TILE_N);
      cj = JW'(ei % TILE_N);
    end
    tcu_dot_lane #(.TILE_K(TILE_K)) u_lane (
      .fmt (op_q.fmt),
      .a   (op_q.a[ri]),
      .b   (op_q.b[cj]),
      .c   (op_q.c[ei]),
      .d   (lane_d[l])
    );
  end

  assign s0_vld  = (state_q == S_ISSUE);
  assign s0_meta = '{pass: pass_q, last: last_pass, tag: op_q.tag, res: lane_d};

  if (LATENCY == 1) begin : g_nopipe
    assign wb_vld  = s0_vld;
    assign wb_meta = s0_meta;
  end else begin : g_pipe
    logic [LATENCY-1:1] vld_pipe_q, vld_pipe_d;
    meta_t              meta_q [LATENCY-1:1];
    meta_t              meta_d [LATENCY-1:1];

    always_comb begin
      vld_pipe_d = vld_pipe_q;
      meta_d     = meta_q;
      if (en) begin
        vld_pipe_d[1] = s0_vld;
        meta_d[1]     = s0_meta;
        for (int s = 2; s < LATENCY; s++) begin
          vld_pipe_d[s] = vld_pipe_q[s-1];
          meta_d[s]     = meta_q[s-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) vld_pipe_q <= '0;
      else       vld_pipe_q <= vld_pipe_d;
    end

    always_ff @(posedge clk) meta_q <= meta_d;

    assign wb_vld  = vld_pipe_q[LATENCY-1];
    assign wb_meta = meta_q[LATENCY-1];
  end

  // Writeback: earlier passes fill the assembly buffer, the last pass
  // publishes buffer + its own lanes as the finished tile.
  always_comb begin
    asm_d       = asm_q;
    out_d_d     = out_d_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    if (en) begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (wb_vld) begin
        if (wb_meta.last) begin
          out_d_d = asm_q;
          for (int l = 0; l < NUM_LANES; l++)
            out_d_d[EW'(int'(wb_meta.pass) * NUM_LANES + l)] = wb_meta.res[l];
          out_tag_d   = wb_meta.tag;
          out_valid_d = 1'b1;
        end else begin
          for (int l = 0; l < NUM_LANES; l++)
            asm_d[EW'(int'(wb_meta.pass) * NUM_LANES + l)] = wb_meta.res[l];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q       <= '0;
      out_d_q     <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      out_d_q     <= out_d_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_d     = out_d_q;
endmodule

// File: tb/tb_tcu_tile_sequencer.sv
// Directed bench for tcu_tile_sequencer: default config plus a
// NUM_LANES=4 / LATENCY=1 instance driven with random operands.

module tb_tcu_tile_sequencer;
  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_fmt, out_valid, out_ready;
  logic [7:0]   in_tag, out_tag;
  logic [255:0] in_a, in_b;
  logic [127:0] in_c, out_d;
  logic         u2_in_valid, u2_in_ready, u2_in_fmt, u2_out_valid, u2_out_ready;
  logic [7:0]   u2_in_tag, u2_out_tag;
  logic [255:0] u2_in_a, u2_in_b;
  logic [127:0] u2_in_c, u2_out_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcu_tile_sequencer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_fmt(in_fmt), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_d(out_d)
  );

  tcu_tile_sequencer #(.NUM_LANES(4), .LATENCY(1)) dut2 (
    .clk(clk), .reset(reset), .in_valid(u2_in_valid), .in_ready(u2_in_ready),
    .in_tag(u2_in_tag), .in_fmt(u2_in_fmt), .in_a(u2_in_a), .in_b(u2_in_b),
    .in_c(u2_in_c), .out_valid(u2_out_valid), .out_ready(u2_out_ready),
    .out_tag(u2_out_tag), .out_d(u2_out_d)
  );

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", name, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] tag, input logic fmt, input logic [255:0] a,
                      input logic [255:0] b, input logic [127:0] c);
    int n = 0;
    in_valid = 1'b1; in_tag = tag; in_fmt = fmt; in_a = a; in_b = b; in_c = c;
    while (!in_ready && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) chk("accept_timeout", 128'(n), 128'(0));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin @(negedge clk); lat++; end
  endtask

  function automatic logic [127:0] model(input logic fmt, input logic [255:0] a,
                                         input logic [255:0] b, input logic [127:0] c);
    logic [127:0] d;
    logic [31:0]  acc, aw, bw;
    int           pa, pb;
    d = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        acc = c[(i*2+j)*32 +: 32];
        for (int k = 0; k < 4; k++) begin
          aw = a[(i*4+k)*32 +: 32];
          bw = b[(j*4+k)*32 +: 32];
          if (fmt) begin
            for (int y = 0; y < 4; y++) begin
              pa  = int'($signed(aw[y*8 +: 8]));
              pb  = int'($signed(bw[y*8 +: 8]));
              acc = acc + 32'(pa * pb);
            end
          end else acc = acc + aw * bw;
        end
        d[(i*2+j)*32 +: 32] = acc;
      end
    return d;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           lat, got, extra;
    logic [7:0]   tags [3];
    logic [127:0] ds [3];
    logic [255:0] ra [6];
    logic [255:0] rb [6];
    logic [127:0] rc [6];
    logic [127:0] rexp [6];

    reset = 1'b1; in_valid = 1'b0; in_tag = '0; in_fmt = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b1;
    u2_in_valid = 1'b0; u2_in_tag = '0; u2_in_fmt = 1'b0;
    u2_in_a = '0; u2_in_b = '0; u2_in_c = '0; u2_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_tag", 128'(out_tag), 128'(0));
    chk("rst_out_d", out_d, 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // int32 basic: 1*5+2*6+3*7+4*8 + 10 = 80
    send(8'h5A, 1'b0, {2{32'd4, 32'd3, 32'd2, 32'd1}}, {2{32'd8, 32'd7, 32'd6, 32'd5}},
         {4{32'd10}});
    wait_out(lat);
    chk("basic_latency", 128'(lat), 128'(4));
    chk("basic_tag", 128'(out_tag), 128'(8'h5A));
    chk("basic_d", out_d, {4{32'd80}});
    @(negedge clk);
    chk("basic_drain", 128'(out_valid), 128'(0));

    // int8x4: 3*2 + 2*2 + (-1)*2 + 1*2 = 10 per word, 40 per element
    send(8'h21, 1'b1, {8{32'h01FF0203}}, {8{32'h02020202}}, 128'(0));
    wait_out(lat);
    chk("int8_latency", 128'(lat), 128'(4));
    chk("int8_d", out_d, {4{32'd40}});
    @(negedge clk);

    // wrap-around: 0x7FFFFFFF*2 + 1 = 0xFFFFFFFF
    send(8'h33, 1'b0, {224'(0), 32'h7FFFFFFF}, {224'(0), 32'd2}, {96'(0), 32'd1});
    wait_out(lat);
    chk("wrap_latency", 128'(lat), 128'(4));
    chk("wrap_d", out_d, {96'(0), 32'hFFFFFFFF});
    @(negedge clk);

    // back-to-back with backpressure: tile t gives 4t + 100t = 104t
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++)
      send(8'(t), 1'b0, {8{32'(t)}}, {8{32'd1}}, {4{32'(100 * t)}});
    for (int s = 0; s < 6; s++) begin
      chk("stall_in_ready", 128'(in_ready), 128'(0));
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_out_tag", 128'(out_tag), 128'(1));
      chk("stall_out_d", out_d, {4{32'd104}});
      @(negedge clk);
    end
    out_ready = 1'b1;
    got = 0;
    for (int n = 0; n < 40 && got < 3; n++) begin
      if (out_valid) begin
        tags[got] = out_tag;
        ds[got]   = out_d;
        got++;
      end
      @(negedge clk);
    end
    chk("b2b_count", 128'(got), 128'(3));
    for (int t = 1; t <= 3; t++) begin
      chk("b2b_tag", 128'(tags[t-1]), 128'(t));
      chk("b2b_d", ds[t-1], {4{32'(104 * t)}});
    end
    extra = 0;
    repeat (10) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    chk("b2b_no_dup", 128'(extra), 128'(0));

    // reset one cycle after accept: the aborted tile never appears
    send(8'h77, 1'b0, {8{32'd9}}, {8{32'd9}}, {4{32'd9}});
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (10) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    chk("abort_no_valid", 128'(extra), 128'(0));
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    // rows 1s / 2s, cols 1s / 3s: d = {24, 8, 12, 4}
    send(8'h44, 1'b0, {{4{32'd2}}, {4{32'd1}}}, {{4{32'd3}}, {4{32'd1}}}, 128'(0));
    wait_out(lat);
    chk("post_abort_latency", 128'(lat), 128'(4));
    chk("post_abort_tag", 128'(out_tag), 128'(8'h44));
    chk("post_abort_d", out_d, {32'd24, 32'd8, 32'd12, 32'd4});
    @(negedge clk);

    // NUM_LANES=4, LATENCY=1: one tile per cycle, result one edge after accept
    for (int n = 0; n < 6; n++) begin
      for (int w = 0; w < 8; w++) begin
        ra[n][w*32 +: 32] = $urandom;
        rb[n][w*32 +: 32] = $urandom;
      end
      for (int w = 0; w < 4; w++) rc[n][w*32 +: 32] = $urandom;
      rexp[n] = model(n[0], ra[n], rb[n], rc[n]);
    end
    for (int n = 0; n < 8; n++) begin
      if (n == 1) chk("sweep_not_early", 128'(u2_out_valid), 128'(0));
      if (n >= 2) begin
        chk("sweep_valid", 128'(u2_out_valid), 128'(1));
        chk("sweep_tag", 128'(u2_out_tag), 128'(8'h10 + n - 2));
        chk("sweep_d", u2_out_d, rexp[n-2]);
      end
      if (n < 6) begin
        chk("sweep_in_ready", 128'(u2_in_ready), 128'(1));
        u2_in_valid = 1'b1; u2_in_tag = 8'(8'h10 + n); u2_in_fmt = n[0];
        u2_in_a = ra[n]; u2_in_b = rb[n]; u2_in_c = rc[n];
      end else u2_in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    chk("sweep_drain", 128'(u2_out_valid), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
